// File: rtl/sys_ctrl_tx.sv
// Serialises register-file reads (1 byte) and ALU results (2 bytes, LSB first) into the TX FIFO.
// Define SYS_CTRL_TX_FRAME_TAG_EN to prefix every frame with a type tag byte (5A read, A5 ALU).
module sys_ctrl_tx #(
   parameter int DATA_W = 8,
   parameter int ALU_W  = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [DATA_W-1:0] RdData,
   input  logic              RdData_Valid,
   input  logic [ALU_W-1:0]  ALU_OUT,
   input  logic              OUT_VALID,
   input  logic              FIFO_FULL,
   output logic [DATA_W-1:0] TX_P_DATA,
   output logic              TX_D_VLD,
   output logic              BUSY,
   output logic              OVERRUN
);

`ifdef SYS_CTRL_TX_FRAME_TAG_EN
   typedef enum logic [2:0] {IDLE, RD_BYTE, ALU_LSB, ALU_MSB, TAG} state_t;
`else
   typedef enum logic [1:0] {IDLE, RD_BYTE, ALU_LSB, ALU_MSB} state_t;
`endif

   state_t            state, next_state;
   logic [DATA_W-1:0] rd_hold;
   logic [ALU_W-1:0]  alu_hold;
   logic [ALU_W-1:0]  send_reg;
   logic              rd_pend, alu_pend;
   logic              overrun;
   logic              load_rd, load_alu;
   logic              send_vld;
`ifdef SYS_CTRL_TX_FRAME_TAG_EN
   logic              frame_alu;
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= IDLE;
         rd_hold  <= '0;
         alu_hold <= '0;
         send_reg <= '0;
         rd_pend  <= 1'b0;
         alu_pend <= 1'b0;
         overrun  <= 1'b0;
`ifdef SYS_CTRL_TX_FRAME_TAG_EN
         frame_alu <= 1'b0;
`endif
      end else begin
         state <= next_state;

         // A capture beats a same-cycle dispatch clear; a dispatched value is not an overrun.
         if (RdData_Valid) begin
            rd_hold <= RdData;
            rd_pend <= 1'b1;
            if (rd_pend && !load_rd)
               overrun <= 1'b1;
         end else if (load_rd) begin
            rd_pend <= 1'b0;
         end

         if (OUT_VALID) begin
            alu_hold <= ALU_OUT;
            alu_pend <= 1'b1;
            if (alu_pend && !load_alu)
               overrun <= 1'b1;
         end else if (load_alu) begin
            alu_pend <= 1'b0;
         end

         if (load_rd)
            send_reg <= {{(ALU_W-DATA_W){1'b0}}, rd_hold};
         else if (load_alu)
            send_reg <= alu_hold;

`ifdef SYS_CTRL_TX_FRAME_TAG_EN
         if (load_rd || load_alu)
            frame_alu <= load_alu;
`endif
      end
   end

   always_comb begin
      next_state = state;
      load_rd    = 1'b0;
      load_alu   = 1'b0;
      send_vld   = (state != IDLE) && !FIFO_FULL;
      case (state)
         IDLE: begin
            if (rd_pend) begin
               load_rd = 1'b1;
`ifdef SYS_CTRL_TX_FRAME_TAG_EN
               next_state = TAG;
`else
               next_state = RD_BYTE;
`endif
            end else if (alu_pend) begin
               load_alu = 1'b1;
`ifdef SYS_CTRL_TX_FRAME_TAG_EN
               next_state = TAG;
`else
               next_state = ALU_LSB;
`endif
            end
         end
         RD_BYTE: if (send_vld) next_state = IDLE;
         ALU_LSB: if (send_vld) next_state = ALU_MSB;
         ALU_MSB: if (send_vld) next_state = IDLE;
`ifdef SYS_CTRL_TX_FRAME_TAG_EN
         TAG:     if (send_vld) next_state = frame_alu ? ALU_LSB : RD_BYTE;
`endif
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      TX_P_DATA = '0;
      case (state)
         RD_BYTE, ALU_LSB: TX_P_DATA = send_reg[DATA_W-1:0];
         ALU_MSB:          TX_P_DATA = send_reg[ALU_W-1:DATA_W];
`ifdef SYS_CTRL_TX_FRAME_TAG_EN
         TAG:              TX_P_DATA = frame_alu ? DATA_W'(8'hA5) : DATA_W'(8'h5A);
`endif
         default:          TX_P_DATA = '0;
      endcase
   end

   assign TX_D_VLD = send_vld;
   assign BUSY     = (state != IDLE);
   assign OVERRUN  = overrun;

endmodule
